if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port rst, input, 1: asynchronous, active-high reset.
REQ-004 Port holdPC, input, 1: from hazard unit; freezes PC and issues no fetch this cycle.
REQ-005 Port IF_ID_Flush, input, 1: from hazard unit; bubbles IF/ID and replays its instruction.
REQ-006 Port isBranch, input, 1: from hazard unit; taken branch resolved in EX.
REQ-007 Port PC_offset, input, 32: sign-extended word offset of the taken branch.
REQ-008 Port PC_plus4_ID_EX, input, 32: PC+4 of the branch instruction in ID/EX.
REQ-009 Port imem_req, output, 1: fetch request to instruction memory.
REQ-010 Port imem_addr, output, 32: fetch address, equal to PC.
REQ-011 Port imem_ack, input, 1: imem_rdata is valid for the imem_addr presented in the same cycle.
REQ-012 Port imem_rdata, input, 32: fetched instruction.
REQ-013 Port inst_IF_ID, output, 32: IF/ID instruction, 0 (NOP) when invalid.
REQ-014 Port PC_plus4_IF_ID, output, 32: IF/ID PC+4.
REQ-015 Port valid_IF_ID, output, 1: IF/ID holds a real instruction.
REQ-016 Port stall_cycles, output, 16: saturating count of cycles with holdPC=1 and isBranch=0.

Function
REQ-017 FSM SHALL have states IDLE and FETCH; reset enters IDLE; IDLE goes to FETCH unconditionally on the next edge; FETCH persists until reset.
REQ-018 imem_req SHALL be 1 only in FETCH with holdPC=0, isBranch=0 and IF_ID_Flush=0.
REQ-019 imem_addr SHALL always equal PC.
REQ-020 imem_ack SHALL be ignored whenever imem_req=0.
REQ-021 Branch target SHALL be computed as PC_plus4_ID_EX + (PC_offset << 2), modulo 2^32.
REQ-022 Per-cycle priority SHALL be isBranch > IF_ID_Flush > holdPC > normal fetch.
REQ-023 isBranch=1 SHALL load the branch target into PC, clear IF/ID (valid=0, inst=0), and discard any same-cycle ack.
REQ-024 IF_ID_Flush=1 with isBranch=0 SHALL clear IF/ID and load PC with PC_plus4_IF_ID - 4 if valid_IF_ID=1; otherwise PC SHALL hold.
REQ-025 holdPC=1 alone SHALL hold PC and all IF/ID contents unchanged.
REQ-026 A normal cycle with imem_ack=1 SHALL load IF/ID with inst=imem_rdata, PC_plus4=PC+4 and valid=1, and SHALL set PC to PC+4.
REQ-027 A normal cycle with imem_ack=0 SHALL hold PC and load a bubble into IF/ID (valid=0, inst=0, PC_plus4 unchanged).
REQ-028 PC increments SHALL wrap modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-029 Fetch latency SHALL be one cycle: an ack at edge N makes the instruction visible on the IF/ID outputs after edge N.
REQ-030 stall_cycles SHALL saturate at 0xFFFF and never wrap.

Reset
REQ-031 On rst=1, the block SHALL asynchronously set PC=0, state=IDLE, inst_IF_ID=0, PC_plus4_IF_ID=0, valid_IF_ID=0 and stall_cycles=0, and hold imem_req=0.
REQ-032 Reset asserted mid-fetch SHALL drop the outstanding request with no IF/ID update; after release, the first request SHALL be to address 0, one cycle after IDLE.

Structure
REQ-033 The FSM state enum, the NOP encoding (32'h0) and the reset PC (32'h0) SHALL reside in the shared pipeline package.
REQ-034 The IF/ID register SHALL be a sub-module named if_id_reg, with load, flush and hold controls.

Verification
REQ-035 Reset release with ack always 1 -> imem_addr sequence 0x0, 0x4, 0x8; valid_IF_ID first rises one cycle after the first request.
REQ-036 With PC=0x10 and IF/ID holding PC+4=0x10, pulse holdPC and IF_ID_Flush together -> IF/ID bubbles, next imem_addr=0x0C, stall_cycles=1.
REQ-037 isBranch=1, PC_plus4_ID_EX=0x20, PC_offset=0xFFFFFFFE, ack=1 same cycle -> PC=0x18, rdata discarded, valid_IF_ID=0.
REQ-038 Raise isBranch, IF_ID_Flush and holdPC in the same cycle -> branch target wins, stall_cycles unchanged.
REQ-039 PC=0xFFFFFFFC with ack -> next PC=0x0; PC_plus4_IF_ID=0x0.
REQ-040 Hold holdPC=1 for 70000 cycles -> stall_cycles=0xFFFF and PC unchanged throughout.

Source files
------------

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared pipeline types and constants for the fetch stage
package if_stage_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  // Word offset scaled to bytes; wraps modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] offset);
    return pc_plus4 + (offset << 2);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction memory request/response bus
interface if_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush, hold and load controls
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        hold,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] inst,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  // Flush beats hold beats load; an unloaded, unheld cycle inserts a bubble that keeps PC+4.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst     <= NOP;
      pc_plus4 <= RESET_PC;
      valid    <= 1'b0;
    end else if (flush) begin
      inst  <= NOP;
      valid <= 1'b0;
    end else if (!hold) begin
      if (load) begin
        inst     <= inst_in;
        pc_plus4 <= pc_plus4_in;
        valid    <= 1'b1;
      end else begin
        inst  <= NOP;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, fetch FSM, IF/ID register, stall counter
module if_stage
  import if_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              holdPC,
  input  logic              IF_ID_Flush,
  input  logic              isBranch,
  input  logic [31:0]       PC_offset,
  input  logic [31:0]       PC_plus4_ID_EX,
  if_stage_if.master        imem,
  output logic [31:0]       inst_IF_ID,
  output logic [31:0]       PC_plus4_IF_ID,
  output logic              valid_IF_ID,
  output logic [15:0]       stall_cycles
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  pc;
  logic [31:0]  pc_next_seq;
  logic         req;
  logic         fetch_ok;

  assign pc_next_seq     = pc + 32'd4;
  assign fetch_ok        = req & imem.imem_ack;
  assign imem.imem_req   = req;
  assign imem.imem_addr  = pc;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // IDLE lasts one cycle; FETCH requests only when no hazard control is active.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   req = !holdPC && !isBranch && !IF_ID_Flush;
      default: state_next = IDLE;
    endcase
  end

  // PC update: branch, then replay of a flushed IF/ID instruction, then hold, then sequential fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (isBranch) begin
      pc <= branch_target(PC_plus4_ID_EX, PC_offset);
    end else if (IF_ID_Flush) begin
      if (valid_IF_ID) pc <= PC_plus4_IF_ID - 32'd4;
    end else if (fetch_ok) begin
      pc <= pc_next_seq;
    end
  end

  // Count hazard stall cycles, saturating at the top of the range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 16'h0;
    end else if (holdPC && !isBranch && stall_cycles != STALL_MAX) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

  if_id_reg u_if_id (
    .clk         (clk),
    .rst         (rst),
    .load        (fetch_ok),
    .flush       (isBranch | IF_ID_Flush),
    .hold        (holdPC),
    .inst_in     (imem.imem_rdata),
    .pc_plus4_in (pc_next_seq),
    .inst        (inst_IF_ID),
    .pc_plus4    (PC_plus4_IF_ID),
    .valid       (valid_IF_ID)
  );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized and directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        holdPC = 1'b0;
  logic        IF_ID_Flush = 1'b0;
  logic        isBranch = 1'b0;
  logic [31:0] PC_offset = 32'h0;
  logic [31:0] PC_plus4_ID_EX = 32'h0;
  logic [31:0] inst_IF_ID;
  logic [31:0] PC_plus4_IF_ID;
  logic        valid_IF_ID;
  logic [15:0] stall_cycles;

  if_stage_if bus ();

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .holdPC         (holdPC),
    .IF_ID_Flush    (IF_ID_Flush),
    .isBranch       (isBranch),
    .PC_offset      (PC_offset),
    .PC_plus4_ID_EX (PC_plus4_ID_EX),
    .imem           (bus),
    .inst_IF_ID     (inst_IF_ID),
    .PC_plus4_IF_ID (PC_plus4_IF_ID),
    .valid_IF_ID    (valid_IF_ID),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference state: cycles since reset (0 = idle cycle), PC, IF/ID contents, stall count.
  int          m_cyc   = 0;
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_inst  = 32'h0;
  logic [31:0] m_pc4   = 32'h0;
  logic        m_valid = 1'b0;
  int          m_stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model advanced from the rules on each clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_stall = 0;
    end else begin
      if (isBranch) begin
        m_pc = PC_plus4_ID_EX + PC_offset * 32'd4;
        m_valid = 1'b0; m_inst = 32'h0;
      end else if (IF_ID_Flush) begin
        if (m_valid) m_pc = m_pc4 - 32'd4;
        m_valid = 1'b0; m_inst = 32'h0;
      end else if (holdPC) begin
        m_pc = m_pc;
      end else if (m_cyc >= 1 && bus.imem_ack) begin
        m_inst = bus.imem_rdata; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end else begin
        m_valid = 1'b0; m_inst = 32'h0;
      end
      if (holdPC && !isBranch && m_stall < 65535) m_stall++;
      if (m_cyc < 2) m_cyc++;
    end
  end

  // Compare every output against the model once per cycle, away from the rising edge.
  always @(negedge clk) begin
    check("imem_req", 32'(bus.imem_req),
          32'(!rst && m_cyc >= 1 && !holdPC && !isBranch && !IF_ID_Flush));
    check("imem_addr", bus.imem_addr, m_pc);
    check("inst_IF_ID", inst_IF_ID, m_inst);
    check("PC_plus4_IF_ID", PC_plus4_IF_ID, m_pc4);
    check("valid_IF_ID", 32'(valid_IF_ID), 32'(m_valid));
    check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hazards();
    holdPC = 1'b0; IF_ID_Flush = 1'b0; isBranch = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hA000_0000;

    // Reset state and sequential fetch from address 0.
    tick(); tick();
    #1;
    check("rst_req", 32'(bus.imem_req), 32'h0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_stall", 32'(stall_cycles), 32'h0);
    rst = 1'b0;
    #1 check("idle_req", 32'(bus.imem_req), 32'h0);
    tick(); bus.imem_rdata = 32'hA000_0001;
    #1 check("first_req", 32'(bus.imem_req), 32'h1);
    check("first_addr", bus.imem_addr, 32'h0);
    check("first_valid", 32'(valid_IF_ID), 32'h0);
    tick(); bus.imem_rdata = 32'hA000_0002;
    #1 check("addr_4", bus.imem_addr, 32'h4);
    check("valid_rise", 32'(valid_IF_ID), 32'h1);
    check("inst_0", inst_IF_ID, 32'hA000_0001);
    tick();
    #1 check("addr_8", bus.imem_addr, 32'h8);
    tick(); tick();
    #1 check("addr_10", bus.imem_addr, 32'h10);
    check("pc4_10", PC_plus4_IF_ID, 32'h10);

    // Hold plus flush: flush replays the IF/ID instruction, hold still counts a stall.
    holdPC = 1'b1; IF_ID_Flush = 1'b1;
    tick(); clear_hazards(); bus.imem_ack = 1'b0;
    #1 check("flush_addr", bus.imem_addr, 32'h0C);
    check("flush_valid", 32'(valid_IF_ID), 32'h0);
    check("flush_stall", 32'(stall_cycles), 32'h1);

    // Branch with a same-cycle ack: target 0x20 + (-2 << 2) = 0x18, data discarded.
    isBranch = 1'b1; PC_plus4_ID_EX = 32'h20; PC_offset = 32'hFFFF_FFFE;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick(); clear_hazards(); bus.imem_ack = 1'b0;
    #1 check("br_addr", bus.imem_addr, 32'h18);
    check("br_valid", 32'(valid_IF_ID), 32'h0);
    check("br_inst", inst_IF_ID, 32'h0);

    // All three hazards at once: 0x100 + 3*4 = 0x10C, stall count untouched.
    isBranch = 1'b1; IF_ID_Flush = 1'b1; holdPC = 1'b1;
    PC_plus4_ID_EX = 32'h100; PC_offset = 32'h3;
    tick(); clear_hazards();
    #1 check("all_addr", bus.imem_addr, 32'h10C);
    check("all_stall", 32'(stall_cycles), 32'h1);

    // Wrap at the top of the address space.
    isBranch = 1'b1; PC_plus4_ID_EX = 32'h0; PC_offset = 32'hFFFF_FFFF;
    tick(); clear_hazards(); bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
    #1 check("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    tick(); bus.imem_ack = 1'b0;
    #1 check("wrap_addr", bus.imem_addr, 32'h0);
    check("wrap_pc4", PC_plus4_IF_ID, 32'h0);
    check("wrap_inst", inst_IF_ID, 32'h1234_5678);

    // Reset in the middle of a fetch.
    bus.imem_ack = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1 check("midrst_req", 32'(bus.imem_req), 32'h0);
    check("midrst_addr", bus.imem_addr, 32'h0);
    check("midrst_valid", 32'(valid_IF_ID), 32'h0);
    tick(); rst = 1'b0;
    #1 check("midrst_idle", 32'(bus.imem_req), 32'h0);
    tick();
    #1 check("midrst_first", 32'(bus.imem_req), 32'h1);
    check("midrst_addr0", bus.imem_addr, 32'h0);

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      tick();
      r = $urandom;
      holdPC      = (r[3:0]   < 4'd3);
      IF_ID_Flush = (r[7:4]   < 4'd2);
      isBranch    = (r[11:8]  < 4'd1);
      bus.imem_ack = (r[15:12] < 4'd10);
      bus.imem_rdata = $urandom;
      PC_offset = {{28{r[19]}}, r[19:16]};
      PC_plus4_ID_EX = (r[23:20] == 4'hF) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      rst = (r[31:24] == 8'h00);
    end
    tick();
    rst = 1'b0; clear_hazards();

    // Long hold: counter saturates, PC never moves.
    rst = 1'b1; bus.imem_ack = 1'b1;
    tick(); rst = 1'b0;
    tick(); tick();
    holdPC = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    #1 check("sat_stall", 32'(stall_cycles), 32'hFFFF);
    check("sat_addr", bus.imem_addr, 32'h4);
    tick();
    #1 check("sat_stall_stays", 32'(stall_cycles), 32'hFFFF);
    clear_hazards();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
